// File: rtl/boot_pkg.sv
// Shared types and constants for the SPI flash boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, HDR, DATA, FINISH, DONE, ERROR
  } boot_state_e;

  localparam logic [7:0] FLASH_READ_CMD = 8'h03;

  // Flash bytes arrive MSB-first, so the first byte lands in [31:24]; images are little-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_boot_shifter.sv
// SPI mode-0 bit engine: SCLK divider, 32-bit TX/RX shift registers, bit counter, back-to-back chaining.
module spi_boot_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [5:0]  len_i,
  input  logic [31:0] tx_data_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        done_o,
  output logic        idle_o,
  output logic [31:0] rx_data_o
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q;
  logic          sclk_q, mosi_q, active_q;
  logic [5:0]    bits_q;
  logic [31:0]   sh_q, rx_q;
  logic          tick, rise, fall;

  assign tick      = active_q && (cnt_q == CW'(CLK_DIV - 1));
  assign rise      = tick && !sclk_q;
  assign fall      = tick && sclk_q;
  assign done_o    = rise && (bits_q == 6'd1);
  assign rx_data_o = {rx_q[30:0], miso_i};
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign idle_o    = !active_q;

  // A start accepted on the last sampling edge only loads sh_q; mosi moves at the next SCLK fall.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      active_q <= 1'b0;
      bits_q   <= '0;
    end else if (!active_q) begin
      if (start_i) begin
        active_q <= 1'b1;
        cnt_q    <= '0;
        sclk_q   <= 1'b0;
        mosi_q   <= tx_data_i[31];
        bits_q   <= len_i;
      end
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
      if (rise) begin
        sclk_q <= 1'b1;
        if (done_o) bits_q <= start_i ? len_i : 6'd0;
        else        bits_q <= bits_q - 6'd1;
      end
      if (fall) begin
        sclk_q <= 1'b0;
        if (bits_q == 6'd0) active_q <= 1'b0;
        else                mosi_q   <= sh_q[31];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rise) rx_q <= rx_data_o;
    if (!active_q && start_i)            sh_q <= {tx_data_i[30:0], 1'b0};
    else if (done_o && start_i)          sh_q <= tx_data_i;
    else if (fall && bits_q != 6'd0)     sh_q <= {sh_q[30:0], 1'b0};
  end

endmodule

// File: rtl/spi_flash_boot_loader.sv
// Boot loader: reads a length-prefixed image from SPI NOR flash (READ 0x03) and writes it into ICCM.
module spi_flash_boot_loader
  import boot_pkg::*;
#(
  parameter int          CLK_DIV    = 4,
  parameter int          ADDR_W     = 12,
  parameter int          MAX_WORDS  = 2048,
  parameter logic [23:0] FLASH_BASE = 24'h000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              boot_i,
  output logic              sclk_o,
  output logic              cs_no,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              iccm_ctrl_we_o,
  output logic [ADDR_W-1:0] iccm_ctrl_addr_o,
  output logic [31:0]       iccm_ctrl_wdata_o,
  output logic              prog_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam int FW  = $clog2(CLK_DIV + 1);

  boot_state_e       state_q, state_d;
  logic              cs_q, cs_d, prst_q, prst_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              we_q, we_d, bad_q, bad_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [WCW-1:0]    nwords_q, nwords_d, wcnt_q, wcnt_d;
  logic [FW-1:0]     fin_q, fin_d;

  logic        sh_start, sh_done, sh_idle;
  logic [5:0]  sh_len;
  logic [31:0] sh_tx, sh_rx, rx_word;

  spi_boot_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (sh_start),
    .len_i     (sh_len),
    .tx_data_i (sh_tx),
    .miso_i    (miso_i),
    .sclk_o    (sclk_o),
    .mosi_o    (mosi_o),
    .done_o    (sh_done),
    .idle_o    (sh_idle),
    .rx_data_o (sh_rx)
  );

  assign rx_word = bswap32(sh_rx);

  always_comb begin
    state_d  = state_q;
    cs_d     = cs_q;
    prst_d   = prst_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    nwords_d = nwords_q;
    wcnt_d   = wcnt_q;
    bad_d    = bad_q;
    fin_d    = fin_q;
    sh_start = 1'b0;
    sh_len   = 6'd32;
    sh_tx    = '0;
    case (state_q)
      IDLE, DONE, ERROR: if (boot_i) begin
        state_d  = CMD;
        cs_d     = 1'b0;
        prst_d   = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        err_d    = 1'b0;
        bad_d    = 1'b0;
        sh_start = 1'b1;
        sh_len   = 6'd8;
        sh_tx    = {FLASH_READ_CMD, 24'h000000};
      end
      CMD: if (sh_done) begin
        state_d  = ADDR;
        sh_start = 1'b1;
        sh_len   = 6'd24;
        sh_tx    = {FLASH_BASE, 8'h00};
      end
      ADDR: if (sh_done) begin
        state_d  = HDR;
        sh_start = 1'b1;
      end
      // A rejected header lets the final SCLK pulse finish before chip select is released.
      HDR: if (sh_done) begin
        if (rx_word == 32'd0 || rx_word > 32'(MAX_WORDS)) begin
          bad_d = 1'b1;
        end else begin
          state_d  = DATA;
          sh_start = 1'b1;
          nwords_d = rx_word[WCW-1:0];
          wcnt_d   = '0;
        end
      end else if (bad_q && sh_idle) begin
        state_d = ERROR;
        cs_d    = 1'b1;
        busy_d  = 1'b0;
        err_d   = 1'b1;
      end
      DATA: if (sh_done) begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'(wcnt_q);
        wdata_d = rx_word;
        wcnt_d  = wcnt_q + WCW'(1);
        if (wcnt_q == nwords_q - WCW'(1)) state_d = FINISH;
        else                              sh_start = 1'b1;
      end
      FINISH: if (sh_idle) begin
        if (!cs_q) begin
          cs_d  = 1'b1;
          fin_d = '0;
        end else if (fin_q == FW'(CLK_DIV - 1)) begin
          state_d = DONE;
          prst_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          fin_d = fin_q + FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cs_q     <= 1'b1;
      prst_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      nwords_q <= '0;
      wcnt_q   <= '0;
      bad_q    <= 1'b0;
      fin_q    <= '0;
    end else begin
      state_q  <= state_d;
      cs_q     <= cs_d;
      prst_q   <= prst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      nwords_q <= nwords_d;
      wcnt_q   <= wcnt_d;
      bad_q    <= bad_d;
      fin_q    <= fin_d;
    end
  end

  assign cs_no             = cs_q;
  assign prog_rst_no       = prst_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign iccm_ctrl_we_o    = we_q;
  assign iccm_ctrl_addr_o  = addr_q;
  assign iccm_ctrl_wdata_o = wdata_q;

endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// Directed bench for spi_flash_boot_loader with a SPI NOR flash behavioural model.
module tb_spi_flash_boot_loader;

  localparam int CD   = 2;
  localparam int MAXW = 64;
  localparam int FMEM = 4 * MAXW + 8;

  logic        clk = 1'b0;
  logic        rst_ni, boot_i;
  logic        sclk_o, cs_no, mosi_o;
  logic        miso = 1'b0;
  logic        we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        prog_rst_no, busy_o, done_o, err_o;

  spi_flash_boot_loader #(
    .CLK_DIV(CD), .ADDR_W(12), .MAX_WORDS(MAXW), .FLASH_BASE(24'h000000)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .boot_i(boot_i),
    .sclk_o(sclk_o), .cs_no(cs_no), .mosi_o(mosi_o), .miso_i(miso),
    .iccm_ctrl_we_o(we), .iccm_ctrl_addr_o(addr), .iccm_ctrl_wdata_o(wdata),
    .prog_rst_no(prog_rst_no), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Flash model: captures the 32-bit command/address, then streams fmem[] MSB-first per byte.
  logic [7:0]  fmem [0:FMEM-1];
  logic [31:0] img_w [0:MAXW-1];
  int          rcnt = 0, ones = 0, bfm_b = 0;
  logic [31:0] cmd_sr = '0;

  always @(negedge cs_no or posedge sclk_o) begin
    if (sclk_o && !cs_no) begin
      if (rcnt < 32) cmd_sr = {cmd_sr[30:0], mosi_o};
      else if (mosi_o) ones++;
      rcnt++;
    end else begin
      rcnt = 0; ones = 0;
    end
  end

  always @(negedge sclk_o) begin
    if (!cs_no && rcnt >= 32) begin
      bfm_b = rcnt - 32;
      miso = ((bfm_b >> 3) < FMEM) ? fmem[bfm_b >> 3][7 - (bfm_b & 7)] : 1'b0;
    end
  end

  // Write capture and protocol monitor.
  int          n_we = 0, prot_err = 0;
  logic [11:0] wa [0:511];
  logic [31:0] wd [0:511];
  logic        we_prev = 1'b0, sclk_prev = 1'b0, mosi_prev = 1'b0;

  always @(negedge clk) begin
    if (we) begin
      if (n_we < 512) begin wa[n_we] = addr; wd[n_we] = wdata; end
      n_we++;
    end
    if (we && we_prev) begin prot_err++; $display("FAIL we_width: we high %0d cycles, required 1", 2); end
    if (sclk_o && cs_no) begin prot_err++; $display("FAIL sclk_cs: sclk=1 with cs_no=1, required sclk=0"); end
    if (sclk_o && sclk_prev && !cs_no && mosi_o !== mosi_prev) begin
      prot_err++; $display("FAIL mosi_stable: mosi changed to %b while sclk high", mosi_o);
    end
    we_prev = we; sclk_prev = sclk_o; mosi_prev = mosi_o;
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_image(input logic [31:0] hdr, input int nw);
    for (int i = 0; i < FMEM; i++) fmem[i] = 8'h5A;
    for (int j = 0; j < 4; j++) fmem[j] = hdr[8*j +: 8];
    for (int k = 0; k < nw; k++)
      for (int j = 0; j < 4; j++) fmem[4 + 4*k + j] = img_w[k][8*j +: 8];
  endtask

  task automatic pulse_boot();
    @(negedge clk); boot_i = 1'b1;
    @(negedge clk); boot_i = 1'b0;
  endtask

  task automatic run_boot(input int tag, input logic [31:0] hdr, input int nw, input logic exp_err,
                          input logic mid_pulse, output int cyc);
    int   base, budget;
    logic pulsed;
    base   = n_we;
    budget = (64 + 32 * nw) * 2 * CD + 20 * CD + 50;
    pulsed = 1'b0;
    set_image(hdr, nw);
    pulse_boot();
    check($sformatf("v%0d_cs_low", tag), cs_no, 1'b0);
    check($sformatf("v%0d_busy_on", tag), busy_o, 1'b1);
    check($sformatf("v%0d_prst_low", tag), prog_rst_no, 1'b0);
    cyc = 0;
    while (!(done_o || err_o) && cyc < budget) begin
      @(negedge clk); cyc++;
      if (mid_pulse && !pulsed && (n_we - base) == 1) begin
        boot_i = 1'b1; @(negedge clk); boot_i = 1'b0; cyc++; pulsed = 1'b1;
      end
    end
    check($sformatf("v%0d_in_time", tag), cyc < budget, 1'b1);
    check($sformatf("v%0d_done", tag), done_o, !exp_err);
    check($sformatf("v%0d_err", tag), err_o, exp_err);
    check($sformatf("v%0d_busy", tag), busy_o, 1'b0);
    check($sformatf("v%0d_prst", tag), prog_rst_no, !exp_err);
    check($sformatf("v%0d_cs", tag), cs_no, 1'b1);
    check($sformatf("v%0d_sclk", tag), sclk_o, 1'b0);
    check($sformatf("v%0d_cmd", tag), cmd_sr, 32'h03000000);
    check($sformatf("v%0d_mosi0", tag), ones, 0);
    check($sformatf("v%0d_nwe", tag), n_we - base, exp_err ? 0 : nw);
    if (!exp_err)
      for (int k = 0; k < nw; k++) begin
        check($sformatf("v%0d_addr%0d", tag, k), wa[base + k], k);
        check($sformatf("v%0d_data%0d", tag, k), wd[base + k], img_w[k]);
      end
  endtask

  typedef struct {
    logic [31:0] hdr;
    int          nw;
    logic [31:0] w0, w1, w2;
    logic        exp_err;
  } vec_t;

  vec_t vecs [0:6];
  int   cyc, base, wstop, diff;

  initial begin
    vecs[0] = '{32'd3,          3, 32'h00000013, 32'hDEADBEEF, 32'h12345678, 1'b0};
    vecs[1] = '{32'd0,          0, 32'h0,        32'h0,        32'h0,        1'b1};
    vecs[2] = '{32'd2049,       0, 32'h0,        32'h0,        32'h0,        1'b1};
    vecs[3] = '{32'd65,         0, 32'h0,        32'h0,        32'h0,        1'b1};
    vecs[4] = '{32'h00010002,   0, 32'h0,        32'h0,        32'h0,        1'b1};
    vecs[5] = '{32'd1,          1, 32'hA5A50F0F, 32'h0,        32'h0,        1'b0};
    vecs[6] = '{32'd2,          2, 32'hFFFFFFFF, 32'h80000001, 32'h0,        1'b0};

    rst_ni = 1'b0; boot_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_sclk", sclk_o, 1'b0);
    check("rst_cs", cs_no, 1'b1);
    check("rst_mosi", mosi_o, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_addr", addr, 12'h000);
    check("rst_wdata", wdata, 32'h0);
    check("rst_prst", prog_rst_no, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    begin
      int bad_cs, bad_sclk;
      bad_cs = 0; bad_sclk = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (cs_no !== 1'b1) bad_cs++;
        if (sclk_o !== 1'b0) bad_sclk++;
      end
      check("idle_cs", bad_cs, 0);
      check("idle_sclk", bad_sclk, 0);
      check("idle_we", n_we, 0);
    end

    for (int v = 0; v < 7; v++) begin
      img_w[0] = vecs[v].w0; img_w[1] = vecs[v].w1; img_w[2] = vecs[v].w2;
      run_boot(v, vecs[v].hdr, vecs[v].nw, vecs[v].exp_err, 1'b0, cyc);
    end

    // Largest image: last write address and total load time.
    for (int k = 0; k < MAXW; k++) img_w[k] = 32'(32'h9E3779B9 * 32'(k + 1));
    run_boot(10, MAXW, MAXW, 1'b0, 1'b0, cyc);
    check("max_last_addr", wa[n_we - 1], MAXW - 1);
    diff = cyc - (64 + 32 * MAXW) * 2 * CD;
    check("max_load_time", (diff >= -(CD + 2) && diff <= CD + 2), 1'b1);

    // Reset in the middle of word 1, then a clean reload.
    img_w[0] = 32'h11112222; img_w[1] = 32'h33334444; img_w[2] = 32'h55556666;
    set_image(32'd3, 3);
    base = n_we;
    pulse_boot();
    cyc = 0;
    while ((n_we - base) < 1 && cyc < 2000) begin @(negedge clk); cyc++; end
    check("abort_word0_seen", n_we - base, 1);
    repeat (40) @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    check("abort_cs", cs_no, 1'b1);
    check("abort_busy", busy_o, 1'b0);
    check("abort_prst", prog_rst_no, 1'b1);
    check("abort_sclk", sclk_o, 1'b0);
    rst_ni = 1'b1;
    wstop = n_we;
    repeat (300) @(negedge clk);
    check("abort_no_we", n_we, wstop);
    check("abort_idle_cs", cs_no, 1'b1);
    run_boot(11, 32'd3, 3, 1'b0, 1'b0, cyc);

    // boot_i pulsed while DATA is in progress must not disturb the load.
    img_w[0] = vecs[0].w0; img_w[1] = vecs[0].w1; img_w[2] = vecs[0].w2;
    run_boot(12, 32'd3, 3, 1'b0, 1'b1, cyc);

    check("protocol", prot_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
